// File: rtl/kernel_sequencer.sv
// rtl/kernel_sequencer.sv - ALU kernel-reduction sequencer with pipeline arbitration
// Optional zero-lane skipping is enabled with `define KSEQ_ZERO_SKIP_EN.
module kernel_sequencer #(
    parameter int BUS   = 4,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LANES-1:0]     kernel_reg,
    input  logic [LANES*BUS-1:0] cache,
    output logic                 busy,
    output logic                 done,
    output logic [BUS-1:0]       kernel_result,
    output logic [3:0]           kernel_flags,
    input  logic                 pipe_valid,
    input  logic [BUS-1:0]       pipe_opa,
    input  logic [BUS-1:0]       pipe_opb,
    input  logic [1:0]           pipe_funtype,
    input  logic [1:0]           pipe_funcode,
    output logic                 pipe_stall,
    output logic [BUS-1:0]       alu_opa,
    output logic [BUS-1:0]       alu_opb,
    output logic [1:0]           alu_funtype,
    output logic [1:0]           alu_funcode,
    input  logic [BUS-1:0]       alu_result,
    input  logic [3:0]           alu_cpsr
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [LANES*BUS-1:0] cache_q;
    logic [LANES-1:0]     kern_q;
    logic [BUS-1:0]       acc;
    logic [3:0]           flags;
    logic [IW-1:0]        idx;
    logic [BUS-1:0]       lane_val;

    assign lane_val = cache_q[idx*BUS +: BUS];

`ifdef KSEQ_ZERO_SKIP_EN
    logic [LANES-1:0] nz_in;
    logic [LANES-1:0] nz_q;
    logic [IW:0]      first_lane;
    logic [IW:0]      next_lane;

    // Returns {found, index} of the lowest nonzero lane at or above 'from'.
    function automatic logic [IW:0] find_lane(input logic [LANES-1:0] nz, input int from);
        logic [IW:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i >= from && nz[i]) begin
                r = {1'b1, IW'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        nz_in = '0;
        nz_q  = '0;
        for (int i = 0; i < LANES; i++) begin
            nz_in[i] = |cache[i*BUS +: BUS];
            nz_q[i]  = |cache_q[i*BUS +: BUS];
        end
        first_lane = find_lane(nz_in, 0);
        next_lane  = find_lane(nz_q, int'(idx) + 1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cache_q       <= '0;
            kern_q        <= '0;
            acc           <= '0;
            flags         <= '0;
            idx           <= '0;
            done          <= 1'b0;
            kernel_result <= '0;
            kernel_flags  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cache_q <= cache;
                        kern_q  <= kernel_reg;
                        acc     <= '0;
                        flags   <= '0;
`ifdef KSEQ_ZERO_SKIP_EN
                        if (first_lane[IW]) begin
                            idx   <= first_lane[IW-1:0];
                            state <= STEP;
                        end else begin
                            idx           <= '0;
                            state         <= DONE;
                            done          <= 1'b1;
                            kernel_result <= '0;
                            kernel_flags  <= '0;
                        end
`else
                        idx   <= '0;
                        state <= STEP;
`endif
                    end
                end
                STEP: begin
                    acc   <= alu_result;
                    flags <= alu_cpsr;
`ifdef KSEQ_ZERO_SKIP_EN
                    if (!next_lane[IW]) begin
`else
                    if (idx == IW'(LANES - 1)) begin
`endif
                        state         <= DONE;
                        done          <= 1'b1;
                        kernel_result <= alu_result;
                        kernel_flags  <= alu_cpsr;
                    end else begin
`ifdef KSEQ_ZERO_SKIP_EN
                        idx <= next_lane[IW-1:0];
`else
                        idx <= idx + IW'(1);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The sequencer owns the ALU only in STEP; DONE already hands it back.
    always_comb begin
        alu_opa     = pipe_opa;
        alu_opb     = pipe_opb;
        alu_funtype = pipe_funtype;
        alu_funcode = pipe_funcode;
        if (state == STEP) begin
            alu_opa     = acc;
            alu_opb     = lane_val;
            alu_funtype = 2'b00;
            alu_funcode = kern_q[idx] ? 2'b00 : 2'b01;
        end
    end

    assign busy       = (state != IDLE);
    assign pipe_stall = pipe_valid & (state == STEP);

endmodule
